// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Frame layout is 8N1: one start bit, eight data bits LSB first, one stop bit.
package uart_pkg;

    localparam int unsigned StartBits = 1;
    localparam int unsigned DataBits  = 8;
    localparam int unsigned StopBits  = 1;
    localparam int unsigned FrameBits = StartBits + DataBits + StopBits;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    // Clock cycles per bit; truncating division, caller guarantees a result of at least 2.
    function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                  input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock synchronous FIFO with first-word-fall-through read data.
// Depth must be a power of two so the pointers wrap without extra logic.
module uart_tx_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [AddrW-1:0] wptr_q, wptr_d;
    logic [AddrW-1:0] rptr_q, rptr_d;
    logic [AddrW:0]   count_q, count_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;
    logic [Width-1:0] mem_q [Depth];

    // Guard against callers pushing into a full FIFO or popping an empty one.
    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & (count_q != '0);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + AddrW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AddrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AddrW+1)'(1);
            2'b01:   count_d = count_q - (AddrW+1)'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == (AddrW+1)'(Depth));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: byte strobes enter a FIFO and are serialised
// back-to-back at a fixed baud rate. All pin-facing outputs come from registers.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       CLK_100M,
    input  logic       SYS_RST_N,
    input  logic       UART_ENC_START_OUT,
    input  logic [7:0] UART_ENC_DATA,
    output logic       UART_TXD,
    output logic       UART_TX_BUSY,
    output logic       UART_TX_FULL,
    output logic       UART_TX_OVF
);

    localparam int unsigned BaudDiv = calc_baud_div(CLK_FREQ, BAUD);
    localparam int unsigned CntW    = $clog2(BaudDiv);
    localparam int unsigned BitW    = $clog2(DataBits);
    localparam int unsigned CountW  = $clog2(FIFO_DEPTH) + 1;

    tx_state_e             state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [DataBits-1:0]   shift_q, shift_d;
    logic                  txd_q, txd_d;
    logic                  busy_q, busy_d;
    logic                  ovf_q, ovf_d;

    logic                  push, pop, baud_end;
    logic [DataBits-1:0]   fifo_rdata;
    logic [CountW-1:0]     fifo_count;
    logic                  fifo_full, fifo_empty;

    // FULL reflects the registered count, so a same-cycle pop never frees room for a strobe.
    assign push  = UART_ENC_START_OUT & ~fifo_full;
    assign ovf_d = UART_ENC_START_OUT & fifo_full;

    uart_tx_fifo #(
        .Width (DataBits),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK_100M),
        .rst_ni  (SYS_RST_N),
        .push_i  (push),
        .wdata_i (UART_ENC_DATA),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign baud_end = (cnt_q == CntW'(BaudDiv - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (baud_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BitW'(DataBits - 1)) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (baud_end) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit so buffered frames leave gap-free.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level is decoded from next state so the pin register tracks the FSM exactly.
        unique case (state_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase

        // A pop always leaves IDLE, so a non-zero count with IDLE next means no pop happened.
        busy_d = (state_d != StIdle) | push | (fifo_count != '0);
    end

    always_ff @(posedge CLK_100M or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign UART_TXD     = txd_q;
    assign UART_TX_BUSY = busy_q;
    assign UART_TX_FULL = fifo_full;
    assign UART_TX_OVF  = ovf_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter stage directly downstream of the UART encoder. It accepts one-cycle byte strobes (start plus 8-bit ASCII), buffers them in a small synchronous FIFO, and serialises each byte as an 8N1 frame on the UART TX pin at a fixed baud rate. It absorbs encoder bursts and makes the frames leave back-to-back without gaps.

## Interface
Parameters:
- CLK_FREQ, 100_000_000: clock frequency in Hz.
- BAUD, 115200: line rate in bit/s. BAUD_DIV = CLK_FREQ / BAUD, integer truncation (868 at defaults). BAUD_DIV must be at least 2.
- FIFO_DEPTH, 16: byte entries. Must be a power of two, at least 2.

Ports:
- CLK_100M  in  1  system clock.
- SYS_RST_N  in  1  reset, asynchronous, active-low.
- UART_ENC_START_OUT  in  1  byte strobe. Each high cycle is one byte.
- UART_ENC_DATA  in  8  byte, valid when the strobe is high.
- UART_TXD  out  1  serial line, idle high.
- UART_TX_BUSY  out  1  high while the FIFO is non-empty or a frame is in progress.
- UART_TX_FULL  out  1  FIFO holds FIFO_DEPTH entries.
- UART_TX_OVF  out  1  one-cycle pulse when a strobe is dropped.

## Operation
- Write: on a strobe cycle, the byte is pushed if FULL is low that cycle. If FULL is high, the byte is dropped and OVF pulses on the next cycle.
- FULL uses the current count. A pop in the same cycle does not make room for a strobe in that cycle.
- A push and a pop in the same cycle leave the count unchanged.
- FSM states are IDLE, START, DATA and STOP. A baud counter runs 0..BAUD_DIV-1, and a bit index runs 0..7.
  - IDLE: TXD=1. If the FIFO is non-empty: pop, load the shift register, clear the counter, go to START.
  - START: TXD=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: TXD=shift[0], LSB first. Each bit lasts BAUD_DIV cycles; the register then shifts right and the index increments. After bit 7, go to STOP.
  - STOP: TXD=1 for BAUD_DIV cycles. On the last STOP cycle, if the FIFO is non-empty, pop and go to START; otherwise go to IDLE.
- Outputs:
  - BUSY = (state != IDLE) OR (count != 0).
  - TXD is driven from a register, so no combinational glitches reach the pin.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.

## Timing
- Reset (asynchronous assert, synchronous release) clears:
  - TXD=1, BUSY=0, FULL=0, OVF=0.
  - FSM=IDLE, FIFO empty, counters 0.
- Reset mid-frame aborts the frame immediately. TXD goes to 1 asynchronously and the buffered bytes are discarded.
- Latency: a strobe accepted at cycle 0 into an empty FIFO with the FSM in IDLE gives count=1 at cycle 1, the pop at cycle 1, and TXD low from cycle 2.
- Frame length is exactly 10*BAUD_DIV cycles: start, 8 data bits, stop.
- Consecutive buffered bytes produce contiguous frames: the next start bit immediately follows the last stop-bit cycle.
- FULL and BUSY are registered and update one cycle after the push or pop that changes the count.
- OVF pulses one cycle after each dropped strobe. Consecutive drops give consecutive pulses.

## Structure
- Shared package uart_pkg:
  - FSM state enum: IDLE, START, DATA, STOP.
  - Frame constants: 1 start bit, 8 data bits, 1 stop bit.
  - Helper function computing BAUD_DIV.
- Sub-module uart_tx_fifo: a synchronous single-clock FIFO with push/pop, data out, count and full/empty flags, parameterised by width and depth. The top level holds the FSM, baud counter, shift register and output registers.

## Test plan
The bench uses CLK_FREQ=1000, BAUD=100 (BAUD_DIV=10) and FIFO_DEPTH=4.
- Single byte: a 0x4F strobe in idle -> TXD low from cycle 2 for 10 cycles, then bits 1,1,1,1,0,0,1,0 of 10 cycles each, then high for 10 cycles. BUSY falls after the frame. FULL and OVF stay 0.
- Burst: strobes with 0x4F, 0x4B, 0x0A on three consecutive cycles -> three contiguous frames of 100 cycles each with no idle gap. BUSY stays high for 300 cycles.
- Overflow: 6 consecutive strobes, 0x30..0x35, in idle -> the first is popped at once. Bytes 0x31..0x34 fill the FIFO, and FULL rises after the fifth strobe. The sixth (0x35) is dropped, and OVF pulses for 1 cycle after it. The transmitted bytes are 0x30..0x34.
- Simultaneous full plus pop: FIFO full, with a strobe on the same cycle as the STOP-end pop -> the strobe is dropped, OVF pulses, and the count becomes FIFO_DEPTH-1.
- Reset mid-frame: SYS_RST_N low during DATA bit 3 with 2 bytes queued -> TXD goes to 1 immediately, and BUSY and FULL go to 0. After release, no frame is emitted until a new strobe arrives.
- Pointer wrap: 12 bytes written one per frame-time -> all 12 bytes are transmitted in order, with correct LSB-first bit patterns across pointer wrap-around.
